pipe_stage_buf: RTL

//  Parametrised inter-stage pipeline buffer, successor to the fixed EX/MEM register: one generic

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_stage_buf_if.sv | 37 +++
 rtl/pipe_entry_reg.sv | 20 ++
 rtl/pipe_stage_buf.sv | 105 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and the default-width entry layout for
// the inter-stage pipeline buffer.
package pipe_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int NUM_WORDS_DEF = 3;
   localparam int ADDR_W_DEF    = 4;
   localparam int CTRL_W_DEF    = 5;

   // Bit positions inside the control vector (EX/MEM assignment).
   localparam int CTRL_MUXWB  = 0;
   localparam int CTRL_MEMRD  = 1;
   localparam int CTRL_MEMWR  = 2;
   localparam int CTRL_REGWR  = 3;
   localparam int CTRL_REGWR0 = 4;

   typedef struct packed {
      logic [NUM_WORDS_DEF*DATA_W_DEF-1:0] data;
      logic [ADDR_W_DEF-1:0]               waddr;
      logic [ADDR_W_DEF-1:0]               raddr;
      logic [CTRL_W_DEF-1:0]               ctrl;
   } pipe_entry_t;

   localparam int ENTRY_W_DEF = $bits(pipe_entry_t);

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream and downstream ports of one pipeline stage buffer, bundled so the
// producing and consuming stages see a single connection point.
interface pipe_stage_buf_if #(
   parameter int DATA_W    = pipe_pkg::DATA_W_DEF,
   parameter int NUM_WORDS = pipe_pkg::NUM_WORDS_DEF,
   parameter int ADDR_W    = pipe_pkg::ADDR_W_DEF,
   parameter int CTRL_W    = pipe_pkg::CTRL_W_DEF
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
   // valid never waits on ready, and payload is only meaningful while valid=1.
   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [NUM_WORDS*DATA_W-1:0] in_data;
   logic [ADDR_W-1:0]           in_waddr;
   logic [ADDR_W-1:0]           in_raddr;
   logic [CTRL_W-1:0]           in_ctrl;
   logic                        out_valid;
   logic                        out_ready;
   logic [NUM_WORDS*DATA_W-1:0] out_data;
   logic [ADDR_W-1:0]           out_waddr;
   logic [ADDR_W-1:0]           out_raddr;
   logic [CTRL_W-1:0]           out_ctrl;
   logic [1:0]                  out_count;

   modport master (
      output flush, in_valid, in_data, in_waddr, in_raddr, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_waddr, out_raddr, out_ctrl, out_count
   );

   modport slave (
      input  flush, in_valid, in_data, in_waddr, in_raddr, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_waddr, out_raddr, out_ctrl, out_count
   );

endinterface

// File: rtl/pipe_entry_reg.sv
// One payload register of the stage buffer: synchronous clear wins over load,
// otherwise the value is held.
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer with valid/ready stall, flush and bubble
// control masking. Define PIPE_STAGE_BUF_SKID_EN for the two-entry skid variant.
module pipe_stage_buf #(
   parameter int DATA_W    = pipe_pkg::DATA_W_DEF,
   parameter int NUM_WORDS = pipe_pkg::NUM_WORDS_DEF,
   parameter int ADDR_W    = pipe_pkg::ADDR_W_DEF,
   parameter int CTRL_W    = pipe_pkg::CTRL_W_DEF
) (
   input logic             clock,
   input logic             reset,
   pipe_stage_buf_if.slave bus
);

   typedef struct packed {
      logic [NUM_WORDS*DATA_W-1:0] data;
      logic [ADDR_W-1:0]           waddr;
      logic [ADDR_W-1:0]           raddr;
      logic [CTRL_W-1:0]           ctrl;
   } entry_t;

   localparam int ENT_W = $bits(entry_t);

   entry_t in_entry;
   entry_t head_d;
   entry_t head_q;
   logic   head_valid;
   logic   head_load;
   logic   do_accept;
   logic   do_release;
   logic   clear;

   assign clear      = ~reset;
   assign in_entry   = {bus.in_data, bus.in_waddr, bus.in_raddr, bus.in_ctrl};
   assign do_accept  = bus.in_valid & bus.in_ready;
   assign do_release = head_valid & bus.out_ready;

   pipe_entry_reg #(.W(ENT_W)) u_head (
      .clock (clock),
      .clear (clear),
      .load  (head_load),
      .d     (head_d),
      .q     (head_q)
   );

`ifdef PIPE_STAGE_BUF_SKID_EN
   entry_t skid_q;
   logic   skid_valid;
   logic   skid_load;

   // in_ready comes straight from a flop, breaking the out_ready->in_ready path.
   assign bus.in_ready = ~skid_valid;
   assign head_d       = skid_valid ? skid_q : in_entry;
   assign head_load    = ~bus.flush & ((do_release & skid_valid) |
                                       (do_accept & (~head_valid | do_release)));
   assign skid_load    = ~bus.flush & do_accept & head_valid & ~do_release;

   pipe_entry_reg #(.W(ENT_W)) u_skid (
      .clock (clock),
      .clear (clear),
      .load  (skid_load),
      .d     (in_entry),
      .q     (skid_q)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (bus.flush) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         head_valid <= do_accept | skid_valid | (head_valid & ~do_release);
         skid_valid <= (skid_valid & ~do_release) | (do_accept & head_valid & ~do_release);
      end
   end

   assign bus.out_count = {head_valid & skid_valid, head_valid ^ skid_valid};
`else
   assign bus.in_ready = ~head_valid | bus.out_ready;
   assign head_d       = in_entry;
   assign head_load    = do_accept & ~bus.flush;

   always_ff @(posedge clock) begin
      if (!reset)
         head_valid <= 1'b0;
      else if (bus.flush)
         head_valid <= 1'b0;
      else if (do_accept)
         head_valid <= 1'b1;
      else if (do_release)
         head_valid <= 1'b0;
   end

   assign bus.out_count = {1'b0, head_valid};
`endif

   // A bubble must never write registers or memory downstream.
   assign bus.out_valid = head_valid;
   assign bus.out_data  = head_q.data;
   assign bus.out_waddr = head_q.waddr;
   assign bus.out_raddr = head_q.raddr;
   assign bus.out_ctrl  = head_q.ctrl & {CTRL_W{head_valid}};

endmodule
